// File: rtl/pc_sequencer_pkg.sv
// Shared encodings and default addresses for the PC sequencer.
// Imported by the interface, the branch comparator and the top.
package pc_sequencer_pkg;

  localparam logic [31:0] DEF_RESET_PC = 32'h0000_3000;
  localparam logic [31:0] DEF_EXC_VEC  = 32'h0000_4180;

  typedef enum logic [1:0] {
    NPC_SEQ = 2'b00,
    NPC_J   = 2'b01,
    NPC_JR  = 2'b10,
    NPC_BR  = 2'b11
  } npc_sel_e;

  typedef enum logic [2:0] {
    CMP_EQ  = 3'd0,
    CMP_NE  = 3'd1,
    CMP_LEZ = 3'd2,
    CMP_GTZ = 3'd3,
    CMP_LTZ = 3'd4,
    CMP_GEZ = 3'd5
  } cmp_mode_e;

  // ST_HELD means a redirect arrived under stall and waits in the held register.
  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HELD = 1'b1
  } seq_state_e;

  // Branch offset: sign-extended word offset converted to a byte offset.
  function automatic logic [31:0] br_offset(input logic [15:0] imm16);
    return {{14{imm16[15]}}, imm16, 2'b00};
  endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Bundle between the ID stage / commit logic and the PC sequencer.
// The sequencer side is the slave modport; the pipeline side is the master.
interface pc_sequencer_if #(
  parameter int AW = 32
);
  import pc_sequencer_pkg::*;

  // No valid/ready handshake here: id_valid qualifies the ID fields for one cycle,
  // redirect is the same-cycle answer, and a redirect seen under stall is absorbed
  // by the sequencer (pending) so ID never has to hold or replay it.
  logic          stall;
  logic          id_valid;
  logic [AW-1:0] id_pc;
  logic [1:0]    npc_sel;
  logic [2:0]    cmp_mode;
  logic [25:0]   imm26;
  logic [15:0]   imm16;
  logic [AW-1:0] rs_data;
  logic [AW-1:0] rt_data;
  logic          exc_req;
  logic          eret_req;
  logic [AW-1:0] epc;

  logic [AW-1:0] pc;
  logic [AW-1:0] pc_plus8;
  logic          redirect;
  logic          pending;
  logic          misalign;
  seq_state_e    seq_state;

  modport master (
    output stall, id_valid, id_pc, npc_sel, cmp_mode, imm26, imm16,
           rs_data, rt_data, exc_req, eret_req, epc,
    input  pc, pc_plus8, redirect, pending, misalign, seq_state
  );

  modport slave (
    input  stall, id_valid, id_pc, npc_sel, cmp_mode, imm26, imm16,
           rs_data, rt_data, exc_req, eret_req, epc,
    output pc, pc_plus8, redirect, pending, misalign, seq_state
  );

endinterface

// File: rtl/pc_sequencer_branch_cmp.sv
// Branch condition evaluation for the ID-stage comparator.
// eq/ne compare raw bit patterns; the zero tests treat rs_data as signed.
module branch_cmp
  import pc_sequencer_pkg::*;
#(
  parameter int AW = 32
) (
  input  logic [AW-1:0] rs_data,
  input  logic [AW-1:0] rt_data,
  input  logic [2:0]    cmp_mode,
  output logic          cond
);

  logic rs_neg;
  logic rs_zero;

  assign rs_neg  = rs_data[AW-1];
  assign rs_zero = (rs_data == '0);

  always_comb begin
    cond = 1'b0;
    case (cmp_mode)
      CMP_EQ:  cond = (rs_data == rt_data);
      CMP_NE:  cond = (rs_data != rt_data);
      CMP_LEZ: cond = rs_neg | rs_zero;
      CMP_GTZ: cond = ~rs_neg & ~rs_zero;
      CMP_LTZ: cond = rs_neg;
      CMP_GEZ: cond = ~rs_neg;
      default: cond = 1'b0;
    endcase
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter unit: owns the PC register, resolves ID-stage redirects and
// defers a redirect that arrives while the front end is stalled.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int            AW          = 32,
  parameter logic [AW-1:0] RESET_PC    = AW'(DEF_RESET_PC),
  parameter logic [AW-1:0] EXC_VEC     = AW'(DEF_EXC_VEC),
  parameter bit            CHECK_ALIGN = 1'b1
) (
  input logic           clk,
  input logic           reset,
  pc_sequencer_if.slave bus
);

  logic [AW-1:0] pc_q;
  logic [AW-1:0] held_q;
  logic [AW-1:0] seq_pc4;
  logic [AW-1:0] br_tgt;
  logic [AW-1:0] j_tgt;
  logic [AW-1:0] tgt;
  logic [AW-1:0] pc_next;
  logic          cond;
  logic          take;
  logic          commit;
  logic          latch_en;
  seq_state_e    state_q;
  seq_state_e    state_d;

  branch_cmp #(.AW(AW)) u_branch_cmp (
    .rs_data  (bus.rs_data),
    .rt_data  (bus.rt_data),
    .cmp_mode (bus.cmp_mode),
    .cond     (cond)
  );

  // Target arithmetic wraps modulo 2^AW; the jump keeps the top nibble of id_pc+4.
  assign seq_pc4 = bus.id_pc + AW'(4);
  assign br_tgt  = seq_pc4 + AW'(br_offset(bus.imm16));
  assign j_tgt   = {seq_pc4[AW-1:28], bus.imm26, 2'b00};

  always_comb begin
    tgt = seq_pc4;
    case (bus.npc_sel)
      NPC_J:   tgt = j_tgt;
      NPC_JR:  tgt = bus.rs_data;
      NPC_BR:  tgt = br_tgt;
      default: tgt = seq_pc4;
    endcase
  end

  assign take = bus.id_valid &&
                ((bus.npc_sel == NPC_J) || (bus.npc_sel == NPC_JR) ||
                 ((bus.npc_sel == NPC_BR) && cond));

  // Exception and ERET commits bypass stall and discard any held redirect.
  assign commit = bus.exc_req | bus.eret_req;

  // FSM: state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    if (commit) begin
      state_d = ST_RUN;
    end else if (bus.stall) begin
      if (take && (state_q == ST_RUN)) begin
        state_d = ST_HELD;
      end
    end else if (state_q == ST_HELD) begin
      state_d = ST_RUN;
    end
  end

  // FSM: outputs and next-PC selection
  always_comb begin
    latch_en = 1'b0;
    pc_next  = pc_q + AW'(4);
    if (bus.exc_req) begin
      pc_next = EXC_VEC;
    end else if (bus.eret_req) begin
      pc_next = bus.epc;
    end else if (bus.stall) begin
      pc_next  = pc_q;
      latch_en = take && (state_q == ST_RUN);
    end else if (state_q == ST_HELD) begin
      // A held redirect beats a same-cycle take; that overlap is upstream's error.
      pc_next = held_q;
    end else if (take) begin
      pc_next = tgt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q   <= RESET_PC;
      held_q <= '0;
    end else begin
      pc_q <= pc_next;
      if (latch_en) begin
        held_q <= tgt;
      end
    end
  end

  assign bus.pc        = pc_q;
  assign bus.pc_plus8  = bus.id_pc + AW'(8);
  assign bus.redirect  = take;
  assign bus.pending   = (state_q == ST_HELD);
  assign bus.misalign  = CHECK_ALIGN && take && (tgt[1:0] != 2'b00);
  assign bus.seq_state = state_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed vector table, then randomized cycles
// compared against a rule-level reference model.
module tb_pc_sequencer;
  import pc_sequencer_pkg::*;

  typedef struct {
    logic        rst;
    logic        stall;
    logic        id_valid;
    logic [1:0]  sel;
    logic [2:0]  mode;
    logic [25:0] imm26;
    logic [15:0] imm16;
    logic [31:0] id_pc;
    logic [31:0] rs;
    logic [31:0] rt;
    logic        exc;
    logic        eret;
    logic [31:0] epc;
    logic        exp_redirect;
    logic        exp_misalign;
    logic [31:0] exp_pc;
    logic        exp_pending;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  logic [31:0] exp_q[$];
  vec_t        vt[$];

  logic [31:0] m_pc;
  logic [31:0] m_held;
  logic        m_pend;

  pc_sequencer_if #(.AW(32)) bus ();

  pc_sequencer #(.AW(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- driver ----------------
  task automatic drive(input vec_t v);
    reset        = v.rst;
    bus.stall    = v.stall;
    bus.id_valid = v.id_valid;
    bus.npc_sel  = v.sel;
    bus.cmp_mode = v.mode;
    bus.imm26    = v.imm26;
    bus.imm16    = v.imm16;
    bus.id_pc    = v.id_pc;
    bus.rs_data  = v.rs;
    bus.rt_data  = v.rt;
    bus.exc_req  = v.exc;
    bus.eret_req = v.eret;
    bus.epc      = v.epc;
  endtask

  function automatic vec_t mk(
    input logic rst, stall, valid, input logic [1:0] sel, input logic [2:0] mode,
    input logic [25:0] imm26, input logic [15:0] imm16,
    input logic [31:0] id_pc, rs, rt, input logic exc, eret, input logic [31:0] epc,
    input logic e_red, e_mis, input logic [31:0] e_pc, input logic e_pend);
    vec_t v;
    v.rst = rst; v.stall = stall; v.id_valid = valid; v.sel = sel; v.mode = mode;
    v.imm26 = imm26; v.imm16 = imm16; v.id_pc = id_pc; v.rs = rs; v.rt = rt;
    v.exc = exc; v.eret = eret; v.epc = epc;
    v.exp_redirect = e_red; v.exp_misalign = e_mis; v.exp_pc = e_pc; v.exp_pending = e_pend;
    return v;
  endfunction

  function automatic vec_t idle(input logic [31:0] e_pc);
    return mk(0,0,0,2'd0,3'd0,26'd0,16'd0,32'd0,32'd0,32'd0,0,0,32'd0, 0,0,e_pc,0);
  endfunction

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic m_cond(input logic [2:0] mode, input logic [31:0] rs, rt);
    case (mode)
      3'd0:    return rs == rt;
      3'd1:    return rs != rt;
      3'd2:    return $signed(rs) <= 0;
      3'd3:    return $signed(rs) > 0;
      3'd4:    return $signed(rs) < 0;
      3'd5:    return $signed(rs) >= 0;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] m_target(input vec_t v);
    logic [31:0] off;
    off = {{16{v.imm16[15]}}, v.imm16};
    case (v.sel)
      2'd1:    return ((v.id_pc + 32'd4) & 32'hF000_0000) | (32'(v.imm26) * 32'd4);
      2'd2:    return v.rs;
      default: return v.id_pc + 32'd4 + off * 32'd4;
    endcase
  endfunction

  function automatic logic m_take(input vec_t v);
    return v.id_valid && (v.sel == 2'd1 || v.sel == 2'd2 ||
                          (v.sel == 2'd3 && m_cond(v.mode, v.rs, v.rt)));
  endfunction

  task automatic model_step(input vec_t v);
    logic        tk;
    logic [31:0] t;
    tk = m_take(v);
    t  = m_target(v);
    if (v.rst) begin
      m_pc = 32'h0000_3000; m_pend = 0; m_held = 0;
    end else if (v.exc) begin
      m_pc = 32'h0000_4180; m_pend = 0;
    end else if (v.eret) begin
      m_pc = v.epc; m_pend = 0;
    end else if (v.stall) begin
      if (tk && !m_pend) begin
        m_held = t; m_pend = 1;
      end
    end else if (m_pend) begin
      m_pc = m_held; m_pend = 0;
    end else if (tk) begin
      m_pc = t;
    end else begin
      m_pc = m_pc + 32'd4;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    vec_t v;
    logic [31:0] r;

    drive(idle(32'd0));
    reset = 1'b1;

    // rst stall val sel mode imm26 imm16 id_pc rs rt exc eret epc | red mis pc pend
    vt.push_back(mk(1,0,0,0,0,0,0,0,0,0,0,0,0, 0,0,32'h3000,0));
    vt.push_back(mk(1,0,0,0,0,0,0,0,0,0,0,0,0, 0,0,32'h3000,0));
    vt.push_back(idle(32'h3004));
    vt.push_back(idle(32'h3008));
    vt.push_back(mk(0,0,1,3,0,0,16'hFFFE,32'h3004,5,5,0,0,0, 1,0,32'h3000,0));
    vt.push_back(mk(0,0,1,3,3,0,16'h0010,32'h3000,32'h8000_0000,0,0,0,0, 0,0,32'h3004,0));
    vt.push_back(mk(0,0,1,3,5,0,16'h0004,32'h3004,0,0,0,0,0, 1,0,32'h3018,0));
    vt.push_back(mk(0,1,1,1,0,26'h0000C10,0,32'h3018,0,0,0,0,0, 1,0,32'h3018,1));
    vt.push_back(mk(0,1,1,1,0,26'h0000C10,0,32'h3018,0,0,0,0,0, 1,0,32'h3018,1));
    vt.push_back(mk(0,1,1,1,0,26'h0000C10,0,32'h3018,0,0,0,0,0, 1,0,32'h3018,1));
    vt.push_back(idle(32'h3040));
    vt.push_back(idle(32'h3044));
    vt.push_back(mk(0,1,1,2,0,0,0,32'h3040,32'h5000,0,0,0,0, 1,0,32'h3044,1));
    vt.push_back(mk(0,1,0,0,0,0,0,0,0,0,1,1,32'h3010, 0,0,32'h4180,0));
    vt.push_back(mk(0,0,0,0,0,0,0,0,0,0,0,1,32'h3010, 0,0,32'h3010,0));
    vt.push_back(mk(0,0,1,2,0,0,0,32'h3008,32'h3002,0,0,0,0, 1,1,32'h3002,0));
    vt.push_back(idle(32'h3006));
    vt.push_back(mk(0,0,1,2,0,0,0,32'h3004,32'hFFFF_FFFC,0,0,0,0, 1,0,32'hFFFF_FFFC,0));
    vt.push_back(idle(32'h0));
    vt.push_back(mk(0,1,1,1,0,26'h100,0,0,0,0,0,0,0, 1,0,32'h0,1));
    vt.push_back(mk(1,1,1,1,0,26'h100,0,0,0,0,0,0,0, 1,0,32'h3000,0));
    vt.push_back(idle(32'h3004));
    vt.push_back(mk(0,1,1,2,0,0,0,32'h3000,32'h6000,0,0,0,0, 1,0,32'h3004,1));
    vt.push_back(mk(0,1,1,2,0,0,0,32'h3000,32'h7000,0,0,0,0, 1,0,32'h3004,1));
    vt.push_back(mk(0,0,1,2,0,0,0,32'h3000,32'h8000,0,0,0,0, 1,0,32'h6000,0));
    vt.push_back(idle(32'h6004));
    vt.push_back(mk(0,0,1,3,1,0,16'h0010,32'h6000,7,7,0,0,0, 0,0,32'h6008,0));
    vt.push_back(mk(0,0,1,3,4,0,16'h0002,32'h6004,32'hFFFF_FFFF,0,0,0,0, 1,0,32'h6010,0));
    vt.push_back(mk(0,0,1,3,2,0,16'hFFFF,32'h6010,0,0,0,0,0, 1,0,32'h6010,0));
    vt.push_back(mk(0,0,1,3,6,0,16'h0040,32'h6010,0,0,0,0,0, 0,0,32'h6014,0));

    @(posedge clk); #1;
    foreach (vt[i]) begin
      drive(vt[i]);
      exp_q.push_back(vt[i].exp_pc);
      @(negedge clk);
      check($sformatf("vec%0d redirect", i), 32'(bus.redirect), 32'(vt[i].exp_redirect));
      check($sformatf("vec%0d misalign", i), 32'(bus.misalign), 32'(vt[i].exp_misalign));
      check($sformatf("vec%0d pc_plus8", i), bus.pc_plus8, vt[i].id_pc + 32'd8);
      @(posedge clk); #1;
      check($sformatf("vec%0d pc", i), bus.pc, exp_q.pop_front());
      check($sformatf("vec%0d pending", i), 32'(bus.pending), 32'(vt[i].exp_pending));
    end

    // Randomized phase: first cycle is a reset so model and DUT start aligned.
    m_pc = 0; m_pend = 0; m_held = 0;
    for (int n = 0; n < 3000; n++) begin
      v = idle(32'd0);
      v.rst      = (n == 0) || ($urandom_range(0, 49) == 0);
      v.stall    = ($urandom_range(0, 3) == 0);
      v.exc      = ($urandom_range(0, 29) == 0);
      v.eret     = ($urandom_range(0, 29) == 0);
      v.id_valid = ($urandom_range(0, 9) < 7);
      v.sel      = 2'($urandom_range(0, 3));
      v.mode     = 3'($urandom_range(0, 7));
      v.imm26    = 26'($urandom());
      v.imm16    = 16'($urandom());
      r          = $urandom();
      v.id_pc    = ($urandom_range(0, 7) == 0) ? r : (r & 32'hFFFF_FFFC);
      case ($urandom_range(0, 3))
        0:       v.rs = 32'd0;
        1:       v.rs = 32'h8000_0000 | $urandom_range(0, 15);
        default: v.rs = ($urandom_range(0, 3) == 0) ? $urandom() : ($urandom() & 32'hFFFF_FFFC);
      endcase
      v.rt  = ($urandom_range(0, 1) == 0) ? v.rs : $urandom();
      v.epc = $urandom() & 32'hFFFF_FFFC;
      drive(v);
      @(negedge clk);
      check("rnd redirect", 32'(bus.redirect), 32'(m_take(v)));
      check("rnd misalign", 32'(bus.misalign), 32'(m_take(v) && (m_target(v) & 32'd3) != 0));
      check("rnd pc_plus8", bus.pc_plus8, v.id_pc + 32'd8);
      model_step(v);
      exp_q.push_back(m_pc);
      @(posedge clk); #1;
      check("rnd pc", bus.pc, exp_q.pop_front());
      check("rnd pending", 32'(bus.pending), 32'(m_pend));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Next-generation program-counter unit for the pipelined MIPS core; replaces the purely combinational next-PC selector.
- Owns the PC register and computes the next PC for sequential, branch, jump, register-jump, exception and ERET flow.
- Branches are resolved in ID and keep MIPS delay-slot semantics. A redirect that arrives while the front end is stalled is held and applied later.
- Sits between the IF-stage instruction memory address port and the ID-stage branch comparator inputs.

Parameters:
AW, 32, PC/address width (≥ 28 + 2).
RESET_PC, 32'h0000_3000, PC value after reset.
EXC_VEC, 32'h0000_4180, exception handler entry address.
CHECK_ALIGN, 1, when 1, a redirect target with bits [1:0] ≠ 0 raises misalign.

Ports:
clk  in  1  system clock.
reset  in  1  synchronous, active-high reset; sampled only on the rising edge of clk.
stall  in  1  freeze the PC register (IF/ID hazard stall).
id_valid  in  1  ID holds a valid control-flow instruction this cycle.
id_pc  in  AW  PC of the instruction in ID.
npc_sel  in  2  00 seq, 01 jump imm26, 10 jump register, 11 conditional branch.
cmp_mode  in  3  branch condition: 000 eq, 001 ne, 010 lez, 011 gtz, 100 ltz, 101 gez; others never taken.
imm26  in  26  J-type field.
imm16  in  16  branch offset.
rs_data  in  AW  forwarded rs value; also the jr target.
rt_data  in  AW  forwarded rt value.
exc_req  in  1  exception commit from a later stage.
eret_req  in  1  ERET commit.
epc  in  AW  return address for ERET.
pc  out  AW  current fetch PC (registered).
pc_plus8  out  AW  id_pc + 8, the link address (combinational).
redirect  out  1  ID redirect is taken this cycle (combinational; drives the IF flush decision).
pending  out  1  a deferred redirect is held (registered).
misalign  out  1  a taken redirect target is unaligned (combinational; gated by CHECK_ALIGN).

Behaviour:
- Reset:
  - pc = RESET_PC.
  - pending = 0; the held target register is cleared to 0.
  - Reset overrides every other input on that edge.
- Target arithmetic (all modulo 2^AW):
  - br_tgt = id_pc + 4 + (sign-extend(imm16) << 2).
  - j_tgt = {(id_pc+4)[AW-1:28], imm26, 2'b00}.
  - jr_tgt = rs_data.
- Compare rules:
  - eq and ne compare rs_data to rt_data as unsigned bit patterns.
  - lez, gtz, ltz and gez evaluate signed rs_data against 0.
- take = id_valid && ((npc_sel == 01) || (npc_sel == 10) || (npc_sel == 11 && cond)). When take = 1, redirect = 1.
- Next-PC priority, evaluated on each rising edge of clk:
  1. reset → RESET_PC.
  2. exc_req → EXC_VEC; pending is cleared. Applies even when stall = 1.
  3. eret_req → epc; pending is cleared. Applies even when stall = 1.
  4. stall = 1:
     - pc is held.
     - If take = 1 and pending = 0: latch the target into the held register and set pending = 1.
     - If take = 1 and pending = 1: the latch is not updated (the older redirect is kept).
  5. pending = 1 → pc = held target; pending = 0. The held redirect wins over a new take in the same cycle; ID is stalled or flushed upstream, so that case is a protocol violation and the held target still wins.
  6. take = 1 → pc = selected target.
  7. otherwise → pc = pc + 4.
- Simultaneous exc_req and eret_req: exc_req wins.
- Delay slot: the slot instruction is already in IF when the redirect is computed; this block never squashes it.
- misalign: reports the target only and does not alter the PC update. Exception raising is done by the CP0 logic.
- Latency: redirect reaches pc one edge after take when stall = 0. Under stall it reaches pc on the first edge after stall falls.
- Wrap-around: pc + 4 at 32'hFFFF_FFFC wraps to 0. No saturation.

Decomposition:
- Shared package:
  - npc_sel encodings: NPC_SEQ, NPC_J, NPC_JR, NPC_BR.
  - cmp_mode encodings: CMP_EQ, CMP_NE, CMP_LEZ, CMP_GTZ, CMP_LTZ, CMP_GEZ.
  - Default RESET_PC and EXC_VEC values.
- One sub-module: branch_cmp. Purely combinational; inputs rs_data, rt_data, cmp_mode; output cond.

Test Plan:
- Reset and sequential fetch: reset high for 2 cycles, then low → pc = 0x3000, 0x3004, 0x3008 on successive edges; pending = 0.
- Taken beq: id_pc = 0x3004, imm16 = 0xFFFE, rs = rt = 5, npc_sel = 11, cmp_mode = eq → redirect = 1; next pc = 0x3004 + 4 − 8 = 0x3000.
- Not-taken branch, then signed compares:
  - bgtz with rs = 0x8000_0000 → not taken; next pc = pc + 4.
  - bgez with rs = 0 → taken.
- Redirect under stall: stall = 1 for 3 cycles while jal imm26 = 0x0000C10 is taken →
  - pc is frozen; pending = 1 from the next edge;
  - after stall falls, pc = 0x0000_3040 and pending = 0;
  - pc_plus8 = id_pc + 8 during the jal cycle.
- Exception priority: exc_req = 1 together with stall = 1, pending = 1 and eret_req = 1 → pc = 0x4180; pending = 0. The following cycle, eret_req with epc = 0x3010 → pc = 0x3010.
- jr misalign and wrap:
  - jr with rs = 0x3002 → misalign = 1 and pc = 0x3002.
  - Separately, pc = 0xFFFF_FFFC with no redirect → next pc = 0x0000_0000.
  - Reset asserted while pending = 1 → pc = 0x3000 and pending = 0.
